// File: rtl/irq_request_arbiter_if.sv
// Handshake bundle between the interrupt level source, the request arbiter and the core.
interface irq_request_arbiter_if #(
  parameter int NUM_IRQ  = 32,
  parameter int ID_WIDTH = 5
);
  logic [NUM_IRQ-1:0]  irq_i;
  logic                irq_enable_i;
  logic                irq_req_o;
  logic [ID_WIDTH-1:0] irq_id_o;
  logic                irq_ack_i;
  logic [NUM_IRQ-1:0]  irq_ack_o;
  logic                busy_o;

  modport master (
    output irq_i, irq_enable_i, irq_ack_i,
    input  irq_req_o, irq_id_o, irq_ack_o, busy_o
  );

  modport slave (
    input  irq_i, irq_enable_i, irq_ack_i,
    output irq_req_o, irq_id_o, irq_ack_o, busy_o
  );
endinterface

// File: rtl/irq_request_arbiter.sv
// Picks one pending interrupt level, requests the core with its ID, returns a one-hot
// acknowledge pulse to the source and then holds off so a slow-dropping level is not re-requested.
module irq_request_arbiter #(
  parameter int NUM_IRQ        = 32,
  parameter int ID_WIDTH       = 5,
  parameter int ROUND_ROBIN    = 0,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  irq_request_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t              r_state, w_stateNext;
  logic                r_req, w_reqNext;
  logic                r_busy;
  logic [ID_WIDTH-1:0] r_id, w_idNext;
  logic [ID_WIDTH-1:0] r_ptr, w_ptrNext;
  logic [ID_WIDTH-1:0] w_winner;
  logic                w_found;
  logic [NUM_IRQ-1:0]  r_ack, w_ackNext;
  logic [NUM_IRQ-1:0]  w_cand;
  logic [3:0]          r_cnt, w_cntNext;

  assign w_cand = bus.irq_enable_i ? bus.irq_i : '0;

  // Search starts at the rotating pointer in round-robin mode, at index 0 otherwise.
  always_comb begin : winnerSearch
    int idx;
    idx      = 0;
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      idx = (ROUND_ROBIN != 0) ? int'(r_ptr) + k : k;
      if (idx >= NUM_IRQ) idx = idx - NUM_IRQ;
      if (!w_found && w_cand[idx[ID_WIDTH-1:0]]) begin
        w_found  = 1'b1;
        w_winner = idx[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin : nextState
    w_stateNext = r_state;
    w_reqNext   = r_req;
    w_idNext    = r_id;
    w_ackNext   = '0;
    w_ptrNext   = r_ptr;
    w_cntNext   = r_cnt;
    case (r_state)
      IDLE: begin
        w_reqNext = 1'b0;
        if (w_found) begin
          w_idNext    = w_winner;
          w_reqNext   = 1'b1;
          w_stateNext = REQ;
        end
      end
      REQ: begin
        // An acknowledge takes precedence over a level that dropped in the same cycle.
        if (bus.irq_ack_i) begin
          w_ackNext[r_id] = 1'b1;
          w_reqNext       = 1'b0;
          w_cntNext       = 4'(HOLDOFF_CYCLES - 1);
          w_stateNext     = HOLD;
          if (ROUND_ROBIN != 0) begin
            w_ptrNext = (r_id == ID_WIDTH'(NUM_IRQ - 1)) ? '0 : r_id + 1'b1;
          end
        end else if (!bus.irq_i[r_id] || !bus.irq_enable_i) begin
          w_reqNext   = 1'b0;
          w_stateNext = IDLE;
        end
      end
      HOLD: begin
        w_reqNext = 1'b0;
        if (r_cnt == 4'd0) begin
          w_stateNext = IDLE;
        end else begin
          w_cntNext = r_cnt - 1'b1;
        end
      end
      default: begin
        w_reqNext   = 1'b0;
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_id    <= '0;
      r_ack   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_req   <= w_reqNext;
      r_id    <= w_idNext;
      r_ack   <= w_ackNext;
      r_ptr   <= w_ptrNext;
      r_cnt   <= w_cntNext;
      r_busy  <= (w_stateNext != IDLE);
    end
  end

  assign bus.irq_req_o = r_req;
  assign bus.irq_id_o  = r_id;
  assign bus.irq_ack_o = r_ack;
  assign bus.busy_o    = r_busy;

endmodule
